// File: rtl/fanctrl_cfg_loader.sv
// fanctrl_cfg_loader
//   Byte-serial configuration loader for the fan-control loop. Framed bytes from the host
//   are assembled into shadow registers (PID a0..b2, SET value, PWM min, PWM period). A
//   COMMIT frame copies every shadow to the active outputs together on the next PID step
//   pulse, so the PID core and PWM never see a partially updated set.
//
//   Optional build macro: FANCTRL_CFG_CHECKSUM_EN
//     When defined, every frame ends with an XOR checksum byte covering the command and the
//     data bytes. A COMMIT frame's checksum is therefore 0xC0.
//
// Ports
//   clk_i                     system clock
//   rst_i                     asynchronous active-high reset
//   config_en_i               configuration mode; frames are accepted only while high
//   dataVaild_STRB_i          one-cycle byte strobe
//   data_i[7:0]               byte, sampled on strobe
//   sync_i                    PID step pulse; commit point
//   a0_o..b2_o                active coefficients, two's complement
//   SET_value_o               active setpoint
//   PWM_minCounterValue_o     active PWM minimum
//   PWM_periodCounterValue_o  active PWM period (ADC_BITWIDTH+1 bits)
//   busy_o                    state is not idle
//   commit_pending_o          waiting for sync_i to apply a commit
//   commit_STRB_o             one-cycle pulse on the cycle the actives update
//   cfg_err_o                 sticky error, cleared by the next valid command byte

module fanctrl_cfg_loader #(
    parameter int unsigned REG_BITWIDTH   = 32,
    parameter int unsigned ADC_BITWIDTH   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    config_en_i,
    input  logic                    dataVaild_STRB_i,
    input  logic [7:0]              data_i,
    input  logic                    sync_i,
    output logic [REG_BITWIDTH-1:0] a0_o,
    output logic [REG_BITWIDTH-1:0] a1_o,
    output logic [REG_BITWIDTH-1:0] b0_o,
    output logic [REG_BITWIDTH-1:0] b1_o,
    output logic [REG_BITWIDTH-1:0] b2_o,
    output logic [ADC_BITWIDTH-1:0] SET_value_o,
    output logic [ADC_BITWIDTH-1:0] PWM_minCounterValue_o,
    output logic [ADC_BITWIDTH:0]   PWM_periodCounterValue_o,
    output logic                    busy_o,
    output logic                    commit_pending_o,
    output logic                    commit_STRB_o,
    output logic                    cfg_err_o
);

    localparam int unsigned NB = REG_BITWIDTH / 8;
    // The assembly path must also hold the 2-byte PWM period.
    localparam int unsigned AW = (REG_BITWIDTH < 16) ? 16 : REG_BITWIDTH;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] CMD_COMMIT = 8'hC0;

`ifdef FANCTRL_CFG_CHECKSUM_EN
    localparam int unsigned CS = 1;
    // Checksum byte arrives after the last data byte, so the full word is held.
    localparam int unsigned SW = AW;
`else
    localparam int unsigned CS = 0;
    // The last data byte is merged on the fly, so only AW-8 bits need storage.
    localparam int unsigned SW = AW - 8;
`endif

    typedef enum logic [1:0] {StIdle, StData, StCommitWait} state_e;

    state_e                  state;
    logic [2:0]              cmd;
    logic [7:0]              cnt;
    logic [TW-1:0]           tmo;
    logic [SW-1:0]           assy;
    logic [AW-1:0]           assy_shift;
    logic [AW-1:0]           wr_val;
    logic [7:0]              cmd_len;
    logic                    strobe;
    logic                    last_byte;
    logic                    do_write;

    logic [REG_BITWIDTH-1:0] sh_coef [5];
    logic [ADC_BITWIDTH-1:0] sh_set;
    logic [ADC_BITWIDTH-1:0] sh_min;
    logic [ADC_BITWIDTH:0]   sh_period;

`ifdef FANCTRL_CFG_CHECKSUM_EN
    logic [7:0]              csum;
    logic                    is_commit;
`endif

    assign busy_o           = (state != StIdle);
    assign commit_pending_o = (state == StCommitWait);

    assign strobe    = dataVaild_STRB_i && config_en_i;
    assign last_byte = (state == StData) && strobe && (cnt == 8'd1);

`ifdef FANCTRL_CFG_CHECKSUM_EN
    assign assy_shift = {assy[AW-9:0], data_i};
    assign wr_val     = assy;
    assign do_write   = last_byte && (data_i == csum) && !is_commit;
`else
    assign assy_shift = {assy, data_i};
    assign wr_val     = assy_shift;
    assign do_write   = last_byte;
`endif

    // Bytes still to come after a write command byte (data plus optional checksum).
    always_comb begin
        cmd_len = 8'd1;
        if (data_i[2:0] < 3'd5) begin
            cmd_len = 8'(NB);
        end else if (data_i[2:0] == 3'd7) begin
            cmd_len = 8'd2;
        end
        cmd_len = cmd_len + 8'(CS);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                    <= StIdle;
            cmd                      <= '0;
            cnt                      <= '0;
            tmo                      <= '0;
            assy                     <= '0;
            for (int i = 0; i < 5; i++) begin
                sh_coef[i] <= '0;
            end
            sh_set                   <= '0;
            sh_min                   <= '0;
            sh_period                <= '0;
            a0_o                     <= '0;
            a1_o                     <= '0;
            b0_o                     <= '0;
            b1_o                     <= '0;
            b2_o                     <= '0;
            SET_value_o              <= '0;
            PWM_minCounterValue_o    <= '0;
            PWM_periodCounterValue_o <= '0;
            commit_STRB_o            <= 1'b0;
            cfg_err_o                <= 1'b0;
`ifdef FANCTRL_CFG_CHECKSUM_EN
            csum                     <= '0;
            is_commit                <= 1'b0;
`endif
        end else begin
            commit_STRB_o <= 1'b0;

            case (state)
                StIdle: begin
                    if (strobe) begin
                        if (data_i <= 8'h07) begin
                            cmd       <= data_i[2:0];
                            cnt       <= cmd_len;
                            tmo       <= '0;
                            assy      <= '0;
                            cfg_err_o <= 1'b0;
                            state     <= StData;
`ifdef FANCTRL_CFG_CHECKSUM_EN
                            csum      <= data_i;
                            is_commit <= 1'b0;
`endif
                        end else if (data_i == CMD_COMMIT) begin
                            cfg_err_o <= 1'b0;
`ifdef FANCTRL_CFG_CHECKSUM_EN
                            // Only the checksum byte remains before the commit arms.
                            cnt       <= 8'd1;
                            tmo       <= '0;
                            csum      <= data_i;
                            is_commit <= 1'b1;
                            state     <= StData;
`else
                            state     <= StCommitWait;
`endif
                        end else begin
                            cfg_err_o <= 1'b1;
                        end
                    end
                end

                StData: begin
                    if (!config_en_i) begin
                        // Leaving config mode mid-frame silently discards the frame.
                        state <= StIdle;
                    end else if (dataVaild_STRB_i) begin
                        tmo <= '0;
                        cnt <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            state <= StIdle;
`ifdef FANCTRL_CFG_CHECKSUM_EN
                            if (data_i != csum) begin
                                cfg_err_o <= 1'b1;
                            end else if (is_commit) begin
                                state <= StCommitWait;
                            end
`endif
                        end else begin
                            assy <= SW'(assy_shift);
`ifdef FANCTRL_CFG_CHECKSUM_EN
                            csum <= csum ^ data_i;
`endif
                        end
                    end else if (tmo == TMO_LAST) begin
                        state     <= StIdle;
                        cfg_err_o <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                StCommitWait: begin
                    // A strobe here is dropped and flagged; it never blocks the commit.
                    if (dataVaild_STRB_i) begin
                        cfg_err_o <= 1'b1;
                    end
                    if (sync_i) begin
                        a0_o                     <= sh_coef[0];
                        a1_o                     <= sh_coef[1];
                        b0_o                     <= sh_coef[2];
                        b1_o                     <= sh_coef[3];
                        b2_o                     <= sh_coef[4];
                        SET_value_o              <= sh_set;
                        PWM_minCounterValue_o    <= sh_min;
                        PWM_periodCounterValue_o <= sh_period;
                        commit_STRB_o            <= 1'b1;
                        state                    <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase

            if (do_write) begin
                case (cmd)
                    3'd5:    sh_set    <= wr_val[ADC_BITWIDTH-1:0];
                    3'd6:    sh_min    <= wr_val[ADC_BITWIDTH-1:0];
                    3'd7:    sh_period <= wr_val[ADC_BITWIDTH:0];
                    default: sh_coef[cmd] <= wr_val[REG_BITWIDTH-1:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fanctrl_cfg_loader.sv
// Directed bench for fanctrl_cfg_loader. Builds with or without FANCTRL_CFG_CHECKSUM_EN;
// frame helpers append the checksum byte when the macro is defined.
module tb_fanctrl_cfg_loader;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic        stb;
    logic [7:0]  data;
    logic        sync;
    logic [31:0] a0, a1, b0, b1, b2;
    logic [7:0]  set_v, pmin;
    logic [8:0]  pper;
    logic        busy, pend, cstb, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fanctrl_cfg_loader #(
        .REG_BITWIDTH  (32),
        .ADC_BITWIDTH  (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .config_en_i             (cfg_en),
        .dataVaild_STRB_i        (stb),
        .data_i                  (data),
        .sync_i                  (sync),
        .a0_o                    (a0),
        .a1_o                    (a1),
        .b0_o                    (b0),
        .b1_o                    (b1),
        .b2_o                    (b2),
        .SET_value_o             (set_v),
        .PWM_minCounterValue_o   (pmin),
        .PWM_periodCounterValue_o(pper),
        .busy_o                  (busy),
        .commit_pending_o        (pend),
        .commit_STRB_o           (cstb),
        .cfg_err_o               (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; strobes exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        stb  = 1'b1;
        data = b;
        @(negedge clk);
        stb  = 1'b0;
        data = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] c, input int n, input logic [31:0] p);
        logic [7:0] x;
        x = c;
        send_byte(c);
        for (int i = n - 1; i >= 0; i--) begin
            send_byte(p[8*i+:8]);
            x = x ^ p[8*i+:8];
        end
`ifdef FANCTRL_CFG_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic commit_cmd();
        send_byte(8'hC0);
`ifdef FANCTRL_CFG_CHECKSUM_EN
        send_byte(8'hC0);
`endif
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_en = 1'b1; stb = 1'b0; sync = 1'b0; data = 8'h00;
        #12;
        chk("rst_b0", b0, 32'h0);
        chk("rst_pper", {23'h0, pper}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // b0 write, held in shadow until commit + sync
        send_frame(8'h02, 4, 32'h12345678);
        chk("b0_idle_after_write", {31'h0, busy}, 32'h0);
        chk("b0_not_yet_active", b0, 32'h0);
        commit_cmd();
        chk("commit_pending", {31'h0, pend}, 32'h1);
        chk("commit_busy", {31'h0, busy}, 32'h1);
        repeat (2) @(negedge clk);
        chk("b0_wait_sync", b0, 32'h0);
        pulse_sync();
        chk("b0_commit", b0, 32'h12345678);
        chk("cstb_high", {31'h0, cstb}, 32'h1);
        chk("a0_untouched", a0, 32'h0);
        chk("pend_cleared", {31'h0, pend}, 32'h0);
        @(negedge clk);
        chk("cstb_one_cycle", {31'h0, cstb}, 32'h0);
        chk("b0_held", b0, 32'h12345678);

        // PWM period keeps 9 bits; SET stays put until a later commit
        send_frame(8'h07, 2, 32'h0000FFFF);
        commit_cmd();
        pulse_sync();
        chk("pper_1ff", {23'h0, pper}, 32'h1FF);
        send_frame(8'h05, 1, 32'h00000080);
        repeat (3) @(negedge clk);
        chk("set_uncommitted", {24'h0, set_v}, 32'h0);
        pulse_sync();
        chk("sync_outside_wait_set", {24'h0, set_v}, 32'h0);
        chk("sync_outside_wait_cstb", {31'h0, cstb}, 32'h0);
        commit_cmd();
        pulse_sync();
        chk("set_committed", {24'h0, set_v}, 32'h80);

        // Illegal command, then a valid one clears the error on accept
        send_byte(8'h09);
        chk("bad_cmd_err", {31'h0, err}, 32'h1);
        chk("bad_cmd_idle", {31'h0, busy}, 32'h0);
        send_byte(8'h06);
        chk("valid_cmd_clears_err", {31'h0, err}, 32'h0);
        chk("valid_cmd_busy", {31'h0, busy}, 32'h1);
        send_byte(8'h11);
`ifdef FANCTRL_CFG_CHECKSUM_EN
        send_byte(8'h17);
`endif
        chk("pmin_frame_done", {31'h0, busy}, 32'h0);

        // Mode drop mid-frame: quiet abort, shadow untouched
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("abort_idle", {31'h0, busy}, 32'h0);
        chk("abort_no_err", {31'h0, err}, 32'h0);
        cfg_en = 1'b1;
        commit_cmd();
        pulse_sync();
        chk("abort_a0_unchanged", a0, 32'h0);
        chk("pmin_committed", {24'h0, pmin}, 32'h11);

        // Inter-byte timeout: abort exactly TMO idle clocks after the last strobe
        send_byte(8'h01);
        send_byte(8'h5A);
        repeat (TMO - 2) @(negedge clk);
        chk("tmo_still_busy", {31'h0, busy}, 32'h1);
        repeat (2) @(negedge clk);
        chk("tmo_idle", {31'h0, busy}, 32'h0);
        chk("tmo_err", {31'h0, err}, 32'h1);

        // Strobe coincident with sync in COMMIT_WAIT: commit wins, byte flagged
        commit_cmd();
        chk("commit_clears_err", {31'h0, err}, 32'h0);
        stb = 1'b1; data = 8'h55; sync = 1'b1;
        @(negedge clk);
        stb = 1'b0; data = 8'h00; sync = 1'b0;
        chk("coinc_cstb", {31'h0, cstb}, 32'h1);
        chk("coinc_err", {31'h0, err}, 32'h1);
        chk("coinc_idle", {31'h0, busy}, 32'h0);
        chk("coinc_a1_discarded", a1, 32'h0);

        // Strobe alone in COMMIT_WAIT, then mode drop does not cancel the commit
        commit_cmd();
        send_byte(8'h33);
        chk("wait_strobe_err", {31'h0, err}, 32'h1);
        chk("wait_strobe_pend", {31'h0, pend}, 32'h1);
        cfg_en = 1'b0;
        @(negedge clk);
        chk("mode_drop_keeps_pend", {31'h0, pend}, 32'h1);
        pulse_sync();
        chk("mode_drop_commit", {31'h0, cstb}, 32'h1);
        chk("mode_drop_idle", {31'h0, busy}, 32'h0);

        // Strobes outside config mode are ignored
        send_byte(8'h02);
        chk("cfg_off_ignored", {31'h0, busy}, 32'h0);
        cfg_en = 1'b1;
        @(negedge clk);

`ifdef FANCTRL_CFG_CHECKSUM_EN
        send_byte(8'h05); send_byte(8'h3C); send_byte(8'h39);
        chk("cs_good_no_err", {31'h0, err}, 32'h0);
        commit_cmd();
        pulse_sync();
        chk("cs_good_set", {24'h0, set_v}, 32'h3C);
        send_byte(8'h05); send_byte(8'h44); send_byte(8'h00);
        chk("cs_bad_err", {31'h0, err}, 32'h1);
        chk("cs_bad_idle", {31'h0, busy}, 32'h0);
        commit_cmd();
        pulse_sync();
        chk("cs_bad_set_unchanged", {24'h0, set_v}, 32'h3C);
        send_byte(8'hC0); send_byte(8'h00);
        chk("cs_commit_bad_err", {31'h0, err}, 32'h1);
        chk("cs_commit_bad_pend", {31'h0, pend}, 32'h0);
        chk("cs_commit_bad_idle", {31'h0, busy}, 32'h0);
`endif

        // Asynchronous reset mid-frame clears everything before the next edge
        send_byte(8'h00);
        send_byte(8'h01);
        #2 rst = 1'b1;
        #1;
        chk("arst_b0", b0, 32'h0);
        chk("arst_pper", {23'h0, pper}, 32'h0);
        chk("arst_pmin", {24'h0, pmin}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fanctrl_cfg_loader.md
Name: fanctrl_cfg_loader

Overview:
- Byte-serial configuration controller for the fan-control loop.
- Assembles framed bytes from the host data interface into shadow registers: PID coefficients a0..b2, SET value, PWM min, PWM period.
- Transfers all shadows to the active outputs atomically on a COMMIT, aligned to the next PID step boundary (sync_i), so the PID core and PWM never see a half-updated coefficient set.

Parameters:
- REG_BITWIDTH, 32, coefficient width; must be a multiple of 8; NB = REG_BITWIDTH/8 bytes per coefficient.
- ADC_BITWIDTH, 8, SET/PWM-min width; PWM period is ADC_BITWIDTH+1 bits.
- TIMEOUT_CYCLES, 65535, idle clocks allowed between bytes inside a frame.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- config_en_i  in  1  configuration mode; frames are accepted only while high.
- dataVaild_STRB_i  in  1  one-cycle byte strobe.
- data_i  in  8  byte, sampled on strobe.
- sync_i  in  1  PID step pulse (PID clock enable).
- a0_o, a1_o, b0_o, b1_o, b2_o  out  REG_BITWIDTH each  active coefficients, signed.
- SET_value_o  out  ADC_BITWIDTH  active setpoint.
- PWM_minCounterValue_o  out  ADC_BITWIDTH  active PWM minimum.
- PWM_periodCounterValue_o  out  ADC_BITWIDTH+1  active PWM period.
- busy_o  out  1  high whenever state is not IDLE.
- commit_pending_o  out  1  high in COMMIT_WAIT.
- commit_STRB_o  out  1  one-cycle pulse on the cycle actives update.
- cfg_err_o  out  1  sticky error flag.

Behaviour:
- Reset: state IDLE; all shadow, active and assembly registers 0; all outputs 0.
- Command byte, accepted in IDLE:
  - 0x00..0x04: write a0, a1, b0, b1, b2; NB data bytes, MSB first.
  - 0x05: SET value, 1 byte.
  - 0x06: PWM min, 1 byte.
  - 0x07: PWM period, 2 bytes MSB first; low ADC_BITWIDTH+1 bits kept, upper bits ignored.
  - 0xC0: COMMIT.
  - Any other value: set cfg_err_o, stay IDLE.
- A valid command byte clears cfg_err_o in the same cycle.
- States:
  - IDLE: on strobe with config_en_i high, decode the command. Write commands go to DATA (byte counter loaded with the byte count); COMMIT goes to COMMIT_WAIT. Strobes with config_en_i low are ignored.
  - DATA: each strobe shifts data_i into the assembly register (left shift 8) and decrements the counter. The last byte writes the assembly value to the addressed shadow register in the same clock, then returns to IDLE. Shadow registers never hold partial data.
  - COMMIT_WAIT: first sync_i seen in this state (earliest the cycle after COMMIT accept) copies every shadow to its active output and pulses commit_STRB_o, then returns to IDLE. Actives change only on that cycle.
- Aborts and errors:
  - config_en_i falls in DATA: abort to IDLE next cycle, assembly discarded, shadow unchanged, no error.
  - config_en_i falls in COMMIT_WAIT: commit still completes; mode change does not cancel it.
  - Timeout: counter clears on every strobe and on DATA entry. Reaching TIMEOUT_CYCLES in DATA aborts to IDLE and sets cfg_err_o.
  - Strobe in COMMIT_WAIT: byte dropped, cfg_err_o set.
- Simultaneous events:
  - sync_i with a strobe in COMMIT_WAIT: commit wins, byte dropped, error set.
  - sync_i outside COMMIT_WAIT: no effect.
- Reset mid-operation: immediate return to IDLE; actives return to 0.
- Latency: shadow is written on the final data byte's clock edge; actives update on the sync_i edge.

Optional Feature:
- Macro: FANCTRL_CFG_CHECKSUM_EN.
- Defined: every write frame carries one extra trailing byte, equal to the XOR of the command byte and all data bytes. The shadow is written on the checksum byte only if it matches; on mismatch the shadow is unchanged and cfg_err_o is set. COMMIT (0xC0) must be followed by checksum 0xC0, else the frame is rejected with an error and the state returns to IDLE.
- Undefined: no checksum byte; behaviour as above.

Test Plan:
- Write 0x02, 0x12, 0x34, 0x56, 0x78, then COMMIT, then sync_i → b0_o = 0x12345678 only on the sync_i cycle. commit_STRB_o high for 1 cycle; other actives stay 0.
- Write 0x07, 0xFF, 0xFF; COMMIT; sync_i → PWM_periodCounterValue_o = 9'h1FF. Then write 0x05, 0x80 without COMMIT → SET_value_o unchanged until a later COMMIT + sync_i.
- Command 0x09 → cfg_err_o = 1, busy_o = 0. Following valid 0x06 clears cfg_err_o.
- Write 0x00 + 2 bytes, then drop config_en_i → busy_o = 0 next cycle, shadow a0 unchanged, cfg_err_o = 0. Write 0x01 + 1 byte, then no strobe for TIMEOUT_CYCLES → IDLE, cfg_err_o = 1.
- COMMIT, then a strobe and sync_i in the same cycle → actives update, byte dropped, cfg_err_o = 1. Assert rst_i mid-frame → all outputs 0 asynchronously.
- With FANCTRL_CFG_CHECKSUM_EN: frame 0x05, 0x3C, checksum 0x39 → shadow SET = 0x3C. Same frame with checksum 0x00 → shadow unchanged, cfg_err_o = 1.
